// File: rtl/bit_seq_tx_if.sv
// bit_seq_tx_if: valid/ready parallel word handshake feeding bit_seq_tx.
interface bit_seq_tx_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic in_ready;
  modport master (output in_valid, in_data, input in_ready);
  modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/bit_seq_tx.sv
// bit_seq_tx: MSB-first serial word transmitter with optional inter-word GAP idle cycles;
// define BIT_SEQ_TX_MATCH_CNT_EN to build the saturating 1011 match counter (else match_cnt is 0).
module bit_seq_tx #(
  parameter int WIDTH = 8,
  parameter int GAP = 0,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rstn,
  bit_seq_tx_if.slave in_if,
  output logic tx_out,
  output logic tx_valid,
  output logic busy,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic tx_out_n, tx_valid_n, last, take;
  assign last = state == S_SHIFT && bcnt == BW'(WIDTH - 1);
  assign in_if.in_ready = state == S_IDLE || (GAP == 0 && last);
  assign take = in_if.in_valid && in_if.in_ready;
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    sr_n = sr;
    bcnt_n = bcnt;
    gcnt_n = gcnt;
    tx_out_n = tx_out;
    tx_valid_n = tx_valid;
    if (take) begin
      state_n = S_SHIFT;
      sr_n = in_if.in_data << 1;
      tx_out_n = in_if.in_data[WIDTH-1];
      tx_valid_n = 1'b1;
      bcnt_n = '0;
    end else if (last) begin
      // final bit leaves the wire with no follow-on word
      state_n = GAP == 0 ? S_IDLE : S_GAP;
      tx_out_n = 1'b0;
      tx_valid_n = 1'b0;
      gcnt_n = '0;
    end else if (state == S_SHIFT) begin
      tx_out_n = sr[WIDTH-1];
      sr_n = sr << 1;
      bcnt_n = bcnt + 1'b1;
    end else if (state == S_GAP) begin
      gcnt_n = gcnt + 1'b1;
      state_n = gcnt == GW'(GAP - 1) ? S_IDLE : S_GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      sr <= '0;
      bcnt <= '0;
      gcnt <= '0;
      tx_out <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      bcnt <= bcnt_n;
      gcnt <= gcnt_n;
      tx_out <= tx_out_n;
      tx_valid <= tx_valid_n;
    end
  end
`ifdef BIT_SEQ_TX_MATCH_CNT_EN
  logic [2:0] hist;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist <= '0;
      match_cnt <= '0;
    end else begin
      hist <= {hist[1:0], tx_out};
      if (tx_valid && {hist, tx_out} == 4'b1011 && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
    end
  end
`else
  assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_bit_seq_tx.sv
// tb_bit_seq_tx: directed and random stimulus against a queue-based stream model for GAP=0 and GAP=2 builds.
module tb_bit_seq_tx;
  logic clk = 1'b0;
  logic rstn0 = 1'b0, rstn1 = 1'b0;
  logic txo0, txv0, busy0, txo1, txv1, busy1;
  logic [7:0] mc0;
  logic [1:0] mc1;
  int passed = 0, total = 0, fails = 0;
  int q[$];
  int cur = 0;
  logic [3:0] mh [2];
  int mcnt [2];
  logic [1:0] strm[$];
`ifdef BIT_SEQ_TX_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  bit_seq_tx_if #(.WIDTH(8)) a ();
  bit_seq_tx_if #(.WIDTH(8)) b ();
  bit_seq_tx #(.WIDTH(8), .GAP(0), .CNT_W(8)) dut0 (
    .clk(clk), .rstn(rstn0), .in_if(a), .tx_out(txo0), .tx_valid(txv0), .busy(busy0), .match_cnt(mc0));
  bit_seq_tx #(.WIDTH(8), .GAP(2), .CNT_W(2)) dut1 (
    .clk(clk), .rstn(rstn1), .in_if(b), .tx_out(txo1), .tx_valid(txv1), .busy(busy1), .match_cnt(mc1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int count_pat(input logic [1:0] s[$]);
    int n = 0;
    logic [3:0] h = '0;
    foreach (s[i]) begin
      h = {h[2:0], s[i][0]};
      if (s[i][1] && h == 4'b1011) n++;
    end
    return n;
  endfunction
  // one clock of the selected DUT: check the cycle on the wire, drive inputs, advance the stream model
  // queue entries: 0 idle, 1 gap, 2 data bit 0, 3 data bit 1
  task automatic cyc(input int sel, input logic v, input logic [7:0] d);
    logic rdy;
    rdy = q.size() == 0 && (sel == 0 || cur == 0);
    chk($sformatf("d%0d.in_ready", sel), sel ? b.in_ready : a.in_ready, rdy);
    chk($sformatf("d%0d.tx_valid", sel), sel ? txv1 : txv0, cur >= 2);
    chk($sformatf("d%0d.tx_out", sel), sel ? txo1 : txo0, cur == 3);
    chk($sformatf("d%0d.busy", sel), sel ? busy1 : busy0, cur != 0);
    chk($sformatf("d%0d.match_cnt", sel), sel ? 32'(mc1) : 32'(mc0), CNT_EN ? mcnt[sel] : 0);
    mh[sel] = {mh[sel][2:0], cur == 3};
    if (cur >= 2 && mh[sel] == 4'b1011 && mcnt[sel] < (sel ? 3 : 255)) mcnt[sel]++;
    mh[1-sel] = {mh[1-sel][2:0], 1'b0};
    if (sel == 0) strm.push_back({cur >= 2, cur == 3});
    a.in_valid = sel == 0 && v;
    b.in_valid = sel == 1 && v;
    a.in_data = d;
    b.in_data = d;
    if (v && rdy) begin
      for (int k = 7; k >= 0; k--) q.push_back(2 + int'(d[k]));
      repeat (sel ? 2 : 0) q.push_back(1);
    end
    cur = q.size() > 0 ? q.pop_front() : 0;
    @(negedge clk);
  endtask
  task automatic rst(input int sel);
    if (sel == 0) rstn0 = 1'b0; else rstn1 = 1'b0;
    a.in_valid = sel == 0;
    b.in_valid = sel == 1;
    a.in_data = 8'hFF;
    b.in_data = 8'hFF;
    @(negedge clk);
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
    q.delete();
    cur = 0;
    mh[sel] = '0;
    mcnt[sel] = 0;
    if (sel == 0) strm.delete();
  endtask
  initial begin
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
    a.in_data = '0;
    b.in_data = '0;
    mh[0] = '0;
    mh[1] = '0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    repeat (2) @(negedge clk);
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    chk("reset.ready0", a.in_ready, 1'b1);
    chk("reset.valid0", txv0, 1'b0);
    chk("reset.ready1", b.in_ready, 1'b1);
    cyc(1, 1'b0, 8'h00);
    cyc(0, 1'b0, 8'h00);
    cyc(0, 1'b1, 8'hB0);
    repeat (10) cyc(0, 1'b0, 8'($urandom));
    chk("single.match", mc0, CNT_EN ? 1 : 0);
    rst(0);
    repeat (9) cyc(0, 1'b1, 8'hBB);
    repeat (10) cyc(0, 1'b0, 8'($urandom));
    chk("b2b.match", mc0, CNT_EN ? 4 : 0);
    cyc(1, 1'b1, 8'hFF);
    repeat (11) cyc(1, 1'b1, 8'h0D);
    repeat (14) cyc(1, 1'b0, 8'($urandom));
    chk("gap.match", mc1, 0);
    rst(0);
    cyc(0, 1'b1, 8'hB4);
    repeat (3) cyc(0, 1'b0, 8'h00);
    rst(0);
    chk("midrst.busy", busy0, 1'b0);
    chk("midrst.in_ready", a.in_ready, 1'b1);
    repeat (3) cyc(0, 1'b0, 8'h00);
    cyc(0, 1'b1, 8'h0B);
    repeat (10) cyc(0, 1'b0, 8'($urandom));
    chk("midrst.match", mc0, CNT_EN ? 1 : 0);
    rst(1);
    repeat (23) cyc(1, 1'b1, 8'hBB);
    repeat (14) cyc(1, 1'b0, 8'h00);
    chk("sat.match", mc1, CNT_EN ? 3 : 0);
    rst(0);
    for (int i = 0; i < 300; i++) cyc(0, 1'($urandom_range(0, 3) != 0), 8'($urandom));
    repeat (12) cyc(0, 1'b0, 8'($urandom));
    chk("rand.cross", mc0, CNT_EN ? count_pat(strm) : 0);
    rst(1);
    for (int i = 0; i < 200; i++) cyc(1, 1'($urandom_range(0, 1)), 8'($urandom));
    repeat (14) cyc(1, 1'b0, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
